// File: rtl/fft_pkg.sv
// Shared FFT package: frame geometry defaults and FSM state types used by the
// input buffer and the fft_controller.
package fft_pkg;

    localparam int unsigned FFT_POINTS_DEF = 512;
    localparam int unsigned DATA_WIDTH_DEF = 24;

    typedef enum logic {
        StFill,
        StFull
    } wr_state_e;

    typedef enum logic {
        StIdle,
        StLocked
    } rd_state_e;

endpackage

// File: rtl/fft_bank_ram.sv
// One frame bank: a synchronous write port and an asynchronous read port.
// Contents are intentionally not reset.
module fft_bank_ram #(
    parameter int unsigned Depth = 512,
    parameter int unsigned Width = 24,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong frame buffer between the audio sample stream and the fft_controller.
// The write bank fills in arrival order; a full frame is swapped to the read side.
module fft_input_buffer
    import fft_pkg::*;
#(
    parameter int unsigned FFT_POINTS = FFT_POINTS_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int unsigned ADDR_W = $clog2(FFT_POINTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic                  i_sample_valid,
    input  logic [ADDR_W-1:0]     i_buffer_read_addr,
    output logic [DATA_WIDTH-1:0] o_buffer_data_out,
    output logic                  o_data_ready,
    input  logic                  i_fft_done,
    output logic                  o_overrun,
    output logic [ADDR_W:0]       o_fill_level
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FFT_POINTS - 1);

    wr_state_e         wr_state_q;
    rd_state_e         rd_state_q;
    logic [ADDR_W-1:0] wptr_q;
    logic              wbank_q;
    logic              data_ready_q;
    logic              overrun_q;

    logic              wr_en;
    logic              last_sample;
    logic              swap;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;

    always_comb begin
        wr_en       = (wr_state_q == StFill) && i_sample_valid;
        last_sample = wr_en && (wptr_q == LastAddr);
        // A done pulse coinciding with the final sample frees the read side in time.
        swap        = (last_sample && ((rd_state_q == StIdle) || i_fft_done)) ||
                      ((wr_state_q == StFull) && (rd_state_q == StIdle));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_state_q   <= StFill;
            rd_state_q   <= StIdle;
            wptr_q       <= '0;
            wbank_q      <= 1'b0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            data_ready_q <= swap;
            if ((wr_state_q == StFull) && i_sample_valid) begin
                overrun_q <= 1'b1;
            end
            if (swap) begin
                wbank_q    <= ~wbank_q;
                wptr_q     <= '0;
                wr_state_q <= StFill;
                rd_state_q <= StLocked;
            end else begin
                if ((rd_state_q == StLocked) && i_fft_done) begin
                    rd_state_q <= StIdle;
                end
                if (last_sample) begin
                    wr_state_q <= StFull;
                end else if (wr_en) begin
                    wptr_q <= wptr_q + 1'b1;
                end
            end
        end
    end

    fft_bank_ram #(
        .Depth (FFT_POINTS),
        .Width (DATA_WIDTH)
    ) u_bank0 (
        .clk_i   (clk),
        .we_i    (wr_en && !wbank_q),
        .waddr_i (wptr_q),
        .wdata_i (i_sample),
        .raddr_i (i_buffer_read_addr),
        .rdata_o (rdata0)
    );

    fft_bank_ram #(
        .Depth (FFT_POINTS),
        .Width (DATA_WIDTH)
    ) u_bank1 (
        .clk_i   (clk),
        .we_i    (wr_en && wbank_q),
        .waddr_i (wptr_q),
        .wdata_i (i_sample),
        .raddr_i (i_buffer_read_addr),
        .rdata_o (rdata1)
    );

    assign o_buffer_data_out = wbank_q ? rdata0 : rdata1;
    assign o_data_ready      = data_ready_q;
    assign o_overrun         = overrun_q;
    assign o_fill_level      = (wr_state_q == StFull) ? (ADDR_W + 1)'(FFT_POINTS)
                                                      : {1'b0, wptr_q};

endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboard bench for fft_input_buffer: a frame-level model queues expected
// hand-overs; a negedge monitor checks pulses, frame contents, fill and overrun.
`timescale 1ns/1ps
module tb_fft_input_buffer;

    localparam int N  = 512;
    localparam int DW = 24;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] i_sample = '0;
    logic          i_sample_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] data_out;
    logic          data_ready;
    logic          fft_done = 1'b0;
    logic          overrun;
    logic [AW:0]   fill_level;

    always #5 clk = ~clk;

    fft_input_buffer #(
        .FFT_POINTS (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i_sample           (i_sample),
        .i_sample_valid     (i_sample_valid),
        .i_buffer_read_addr (rd_addr),
        .o_buffer_data_out  (data_out),
        .o_data_ready       (data_ready),
        .i_fft_done         (fft_done),
        .o_overrun          (overrun),
        .o_fill_level       (fill_level)
    );

    int tests = 0;
    int fails = 0;
    int edges = 0;
    bit checking = 0;

    // Frame-level reference: samples of the frame being collected, whether a
    // complete frame is waiting, whether the consumer holds a frame.
    logic [DW-1:0] m_cur[$];
    bit            m_full = 0;
    bit            m_locked = 0;
    bit            m_ovr = 0;
    logic [DW-1:0] exp_words[$];
    int            exp_edge[$];

    task automatic model_step(input bit v, input logic [DW-1:0] d, input bit done,
                              input bit rstn);
        bit was_locked;
        bit swap;
        if (!rstn) begin
            m_cur.delete();
            m_full   = 0;
            m_locked = 0;
            m_ovr    = 0;
            return;
        end
        was_locked = m_locked;
        swap = 0;
        if (m_full) begin
            if (v) m_ovr = 1;
            if (!was_locked) swap = 1;
        end else if (v) begin
            m_cur.push_back(d);
            if (m_cur.size() == N) begin
                if (!was_locked || done) swap = 1;
                else m_full = 1;
            end
        end
        if (swap) begin
            foreach (m_cur[i]) exp_words.push_back(m_cur[i]);
            exp_edge.push_back(edges);
            m_cur.delete();
            m_full   = 0;
            m_locked = 1;
        end else if (done && was_locked) begin
            m_locked = 0;
        end
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit done, input bit rstn);
        i_sample_valid = v;
        i_sample       = d;
        fft_done       = done;
        reset          = rstn;
        @(posedge clk);
        edges++;
        model_step(v, d, done, rstn);
        #1;
    endtask

    task automatic frame(input int base, input int count, input bit done_on_last);
        for (int k = 0; k < count; k++) begin
            cycle(1'b1, DW'(base + k), done_on_last && (k == count - 1), 1'b1);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    // Monitor: sweeps the read bank in small steps well before the next rising edge.
    always @(negedge clk) begin
        if (checking) begin
            int exp_fill;
            exp_fill = m_full ? N : m_cur.size();
            tests++;
            if (fill_level !== (AW + 1)'(exp_fill)) begin
                fails++;
                $display("FAIL fill_level edge %0d: got %0d want %0d", edges, fill_level, exp_fill);
            end
            tests++;
            if (overrun !== m_ovr) begin
                fails++;
                $display("FAIL overrun edge %0d: got %b want %b", edges, overrun, m_ovr);
            end
            if (exp_edge.size() > 0 && exp_edge[0] == edges) begin
                bit            bad;
                int            bad_a;
                logic [DW-1:0] got, want, w;
                void'(exp_edge.pop_front());
                tests++;
                if (data_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL data_ready_pulse edge %0d: got %b want 1", edges, data_ready);
                end
                bad = 0;
                bad_a = 0;
                got = '0;
                want = '0;
                for (int a = 0; a < N; a++) begin
                    rd_addr = AW'(a);
                    #0.005;
                    w = exp_words.pop_front();
                    if (data_out !== w && !bad) begin
                        bad = 1;
                        bad_a = a;
                        got = data_out;
                        want = w;
                    end
                end
                tests++;
                if (bad) begin
                    fails++;
                    $display("FAIL frame_data edge %0d addr %0d: got %0d want %0d",
                             edges, bad_a, got, want);
                end
            end else begin
                tests++;
                if (data_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL spurious_data_ready edge %0d: got %b want 0", edges, data_ready);
                end
            end
        end
    end

    initial begin
        cycle(1'b0, '0, 1'b0, 1'b0);
        checking = 1;
        cycle(1'b0, '0, 1'b0, 1'b0);
        idle(2);

        // First frame k+1, then a second frame while locked overflows into FULL.
        frame(1, N, 1'b0);
        idle(3);
        frame(1000, N, 1'b0);
        frame(77, 3, 1'b0);
        // Release in FULL: swap next edge, the sample on that edge is dropped.
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, DW'(5555), 1'b0, 1'b1);
        frame(3000, 10, 1'b0);

        // Final sample coinciding with done.
        cycle(1'b0, '0, 1'b0, 1'b0);
        frame(4000, N, 1'b0);
        idle(2);
        frame(5000, N, 1'b1);
        idle(2);

        // Reset mid-frame, then a clean frame.
        frame(6000, 200, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        frame(1, N, 1'b0);
        idle(2);

        // Done while idle is ignored.
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        idle(2);
        frame(7000, 50, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        idle(2);

        // Randomized traffic.
        for (int k = 0; k < 5000; k++) begin
            cycle($urandom_range(99) < 75, DW'($urandom()), $urandom_range(199) == 0,
                  $urandom_range(2999) != 0);
        end
        idle(4);

        tests++;
        if (exp_edge.size() != 0) begin
            fails++;
            $display("FAIL pending_handover: got %0d outstanding want 0", exp_edge.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_input_buffer.md
FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 Parameter FFT_POINTS, default 512: samples per frame; a power of two of at least 4.
REQ-002 Parameter DATA_WIDTH, default 24: sample width in bits.
REQ-003 Localparam ADDR_W = $clog2(FFT_POINTS), default 9.
REQ-004 clk  in  1: single clock; all logic on the rising edge.
REQ-005 reset  in  1: synchronous, active-low reset; block held in reset while reset==0 at a rising edge.
REQ-006 i_sample  in  DATA_WIDTH: incoming audio sample.
REQ-007 i_sample_valid  in  1: i_sample is valid this cycle; no back-pressure exists.
REQ-008 i_buffer_read_addr  in  ADDR_W: read address from the fft_controller into the read bank.
REQ-009 o_buffer_data_out  out  DATA_WIDTH: read-bank word at i_buffer_read_addr, combinational (zero latency).
REQ-010 o_data_ready  out  1: one-cycle pulse when a full frame is handed to the fft_controller.
REQ-011 i_fft_done  in  1: fft_controller done pulse; releases the read bank.
REQ-012 o_overrun  out  1: sticky flag, samples were dropped.
REQ-013 o_fill_level  out  ADDR_W+1: number of samples in the write bank, 0..FFT_POINTS.

Function
REQ-014 The block SHALL hold two banks of FFT_POINTS x DATA_WIDTH (ping-pong), selected by register wbank; the write bank is wbank and the read bank is ~wbank.
REQ-015 Write side FSM states: FILL, FULL.
REQ-016 Read side FSM states: IDLE, LOCKED.
REQ-017 In FILL with i_sample_valid=1, the block SHALL write i_sample to bank[wbank][wptr] and increment wptr.
REQ-018 Samples SHALL be stored in arrival order; address 0 holds the oldest sample of the frame.
REQ-019 When the accepted sample has wptr==FFT_POINTS-1 and the read side is IDLE, on that edge the block SHALL: toggle wbank, clear wptr to 0, set the read side to LOCKED, and stay in FILL.
REQ-020 If the read side is LOCKED in the REQ-019 case, the write side SHALL go to FULL with fill level FFT_POINTS.
REQ-021 In FULL, every sample with i_sample_valid=1 SHALL be dropped, and o_overrun SHALL be set and held until reset.
REQ-022 From FULL, on the first edge at which the read side is IDLE, the block SHALL perform the swap of REQ-019 and return to FILL with wptr=0; a sample valid on that same edge is dropped.
REQ-023 o_data_ready SHALL be registered and high for exactly the one cycle following each swap edge; it SHALL never be high on two consecutive cycles.
REQ-024 i_fft_done while LOCKED SHALL return the read side to IDLE on that edge; i_fft_done while IDLE SHALL be ignored.
REQ-025 Simultaneous final sample and i_fft_done while LOCKED: the block SHALL swap on that edge (release and lock take effect together) and pulse o_data_ready; no overrun occurs.
REQ-026 The read bank SHALL be stable for the whole period the read side is LOCKED.
REQ-027 o_fill_level SHALL equal wptr in FILL and FFT_POINTS in FULL.
REQ-028 Pointer arithmetic is unsigned and modulo ADDR_W bits; wptr SHALL never exceed FFT_POINTS-1.

Reset
REQ-029 On reset: wptr=0, wbank=0, write FSM=FILL, read FSM=IDLE, o_data_ready=0, o_overrun=0, o_fill_level=0.
REQ-030 Bank contents SHALL NOT be reset; o_buffer_data_out is undefined until the first o_data_ready.
REQ-031 Reset mid-frame SHALL discard the partial frame, and the first post-reset sample SHALL land at address 0 of bank 0.

Structure
REQ-032 FFT_POINTS and DATA_WIDTH defaults SHALL come from the shared FFT package (fft_pkg) that the fft_controller also uses.
REQ-033 One sub-module, fft_bank_ram: one synchronous write port and one asynchronous read port, instantiated twice.
REQ-034 All FSMs and pointers SHALL reside in fft_input_buffer.

Verification
REQ-035 Reset, then 512 valid samples of value k+1 (k=0..511): o_data_ready pulses once, one cycle after the 512th sample edge; read addr 0 returns 1, addr 511 returns 512; o_overrun=0.
REQ-036 A second frame of value k+1000 while LOCKED, no i_fft_done: o_fill_level reaches 512, the write side goes FULL, 3 further samples are dropped, o_overrun=1; the read bank still returns 1..512.
REQ-037 i_fft_done in FULL: swap, o_data_ready one-cycle pulse, addr 0 returns 1000; the next sample is written at wptr 0.
REQ-038 512th sample and i_fft_done on the same edge: exactly one o_data_ready pulse; o_overrun stays 0.
REQ-039 Reset (reset=0 for one edge) after 200 samples: o_fill_level=0, no o_data_ready; a new 512-sample frame then behaves as in REQ-035.
REQ-040 i_fft_done while IDLE: no state change and no o_data_ready.
